// File: rtl/saci_pkg.sv
// Shared types and constants for the SACI arbiter slice.
package saci_pkg;

  localparam int SACI_DWIDTH = 53;
  localparam int SACI_MASK_W = 3;
  localparam logic [SACI_MASK_W-1:0] SACI_MASK_NONE = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_BUSY,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } saci_state_e;

  function automatic int saci_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int saci_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/saci_arbiter_if.sv
// Command/handshake link between the arbiter and the SACI master engine.
interface saci_arbiter_if
  import saci_pkg::*;
#(
    parameter int g_dwidth = SACI_DWIDTH
) ();

    logic                   m_start;
    logic [g_dwidth-1:0]    m_data;
    logic [SACI_MASK_W-1:0] m_mask;
    logic                   m_busy;

    // The arbiter side issues commands; the master engine answers with busy.
    modport master (
        output m_start,
        output m_data,
        output m_mask,
        input  m_busy
    );

    modport slave (
        input  m_start,
        input  m_data,
        input  m_mask,
        output m_busy
    );

endinterface

// File: rtl/saci_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module saci_rr_pick
  import saci_pkg::*;
#(
    parameter  int g_nreq = 4,
    localparam int IW     = saci_idx_w(g_nreq)
) (
    input  logic [g_nreq-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [g_nreq-1:0] grant,
    output logic [IW-1:0]     index,
    output logic              valid
);

    logic [IW-1:0] cand;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise any path that skips an assignment infers a latch.
        grant = '0;
        index = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 0; i < g_nreq; i++) begin
            cand = IW'((int'(ptr) + i) % g_nreq);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                index       = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/saci_arbiter.sv
// Round-robin arbiter sharing one SACI master between g_nreq requesters,
// with start and run watchdogs that fail the transaction instead of hanging.
module saci_arbiter
  import saci_pkg::*;
#(
    parameter int g_dwidth        = SACI_DWIDTH,
    parameter int g_nreq          = 4,
    parameter int g_start_timeout = 8,
    parameter int g_run_timeout   = 4096
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [g_nreq-1:0]                    req_i,
    input  logic [g_nreq-1:0][g_dwidth-1:0]      req_data_i,
    input  logic [g_nreq-1:0][SACI_MASK_W-1:0]   req_mask_i,
    output logic [g_nreq-1:0]                    ack_o,
    output logic [g_nreq-1:0]                    err_o,
    output logic [g_nreq-1:0]                    grant_o,
    output logic                                 busy_o,
    saci_arbiter_if.master                       m
);

    localparam int IW = saci_idx_w(g_nreq);
    localparam int CW = $clog2(saci_max(g_start_timeout, g_run_timeout) + 1);

    localparam logic [CW-1:0] START_LAST = CW'(g_start_timeout - 1);
    localparam logic [CW-1:0] RUN_LAST   = CW'(g_run_timeout - 1);
    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [IW-1:0] IDX_LAST   = IW'(g_nreq - 1);

    saci_state_e state_q, state_d;

    logic [CW-1:0]          cnt_q;
    logic [g_nreq-1:0]      grant_q;
    logic [IW-1:0]          idx_q;
    logic [IW-1:0]          rr_ptr_q;
    logic [g_dwidth-1:0]    data_q;
    logic [SACI_MASK_W-1:0] mask_q;

    logic [g_nreq-1:0]      pick_grant;
    logic [IW-1:0]          pick_idx;
    logic                   pick_valid;

    saci_rr_pick #(
        .g_nreq (g_nreq)
    ) u_pick (
        .req   (req_i),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .index (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk_i) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process evaluation order.
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // A master still busy from an earlier timed-out command blocks arbitration.
            ST_IDLE:      if (pick_valid && !m.m_busy) state_d = ST_START;
            ST_START:     state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (m.m_busy)                 state_d = ST_RUN;
                else if (cnt_q >= START_LAST) state_d = ST_ERR;
            end
            ST_RUN: begin
                if (!m.m_busy)              state_d = ST_DONE;
                else if (cnt_q >= RUN_LAST) state_d = ST_ERR;
            end
            ST_DONE:      state_d = ST_IDLE;
            ST_ERR:       state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Watchdog: restarts on every state change, saturates instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if ((state_q == ST_WAIT_BUSY || state_q == ST_RUN) && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Winner's command is captured once and held until the transaction closes.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            grant_q  <= '0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            data_q   <= '0;
            mask_q   <= SACI_MASK_NONE;
        end else if (state_q == ST_IDLE && state_d == ST_START) begin
            grant_q <= pick_grant;
            idx_q   <= pick_idx;
            data_q  <= req_data_i[pick_idx];
            mask_q  <= req_mask_i[pick_idx];
        end else if (state_q == ST_DONE || state_q == ST_ERR) begin
            grant_q  <= '0;
            rr_ptr_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            data_q   <= '0;
            mask_q   <= SACI_MASK_NONE;
        end
    end

    always_comb begin
        m.m_start = (state_q == ST_START);
        m.m_data  = data_q;
        m.m_mask  = mask_q;
        grant_o   = grant_q;
        busy_o    = (state_q != ST_IDLE);
        ack_o     = '0;
        err_o     = '0;
        if (state_q == ST_DONE) ack_o = grant_q;
        if (state_q == ST_ERR)  err_o = grant_q;
    end

endmodule

// File: tb/tb_saci_arbiter.sv
// Self-checking bench: timeline-level reference model plus directed scenarios.
module tb_saci_arbiter;
    import saci_pkg::*;

    localparam int DW     = 53;
    localparam int NR     = 4;
    localparam int ST_TO  = 8;
    localparam int RUN_TO = 4096;

    logic                  clk = 1'b0;
    logic                  reset_i;
    logic [NR-1:0]         req_i;
    logic [NR-1:0][DW-1:0] req_data_i;
    logic [NR-1:0][2:0]    req_mask_i;
    logic [NR-1:0]         ack_o, err_o, grant_o;
    logic                  busy_o;

    saci_arbiter_if #(.g_dwidth(DW)) sif ();

    saci_arbiter #(
        .g_dwidth        (DW),
        .g_nreq          (NR),
        .g_start_timeout (ST_TO),
        .g_run_timeout   (RUN_TO)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .req_i      (req_i),
        .req_data_i (req_data_i),
        .req_mask_i (req_mask_i),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .grant_o    (grant_o),
        .busy_o     (busy_o),
        .m          (sif.master)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Master behaviour plan for the next grant: busy rises plan_d cycles after
    // WAIT_BUSY entry and stays high plan_l cycles; plan_d < 0 means never.
    int plan_d = 0;
    int plan_l = 1;

    // Reference model: one transaction as a timeline of absolute cycles.
    bit              mdl_active = 1'b0;
    int              mdl_owner  = 0;
    int              mdl_s      = 0;
    int              mdl_e      = 0;
    bit              mdl_ok     = 1'b0;
    logic [DW-1:0]   mdl_data;
    logic [2:0]      mdl_mask;
    int              mdl_ptr    = 0;
    int              b_rise     = 0;
    int              b_fall     = 0;
    int              mdl_w, mdl_r, mdl_idx;
    bit              mdl_found;
    logic [NR-1:0]   eg, ea, ee;

    // Observed events, used against hand-computed literals.
    int              start_cyc = -1;
    int              ack_cyc   = -1;
    int              err_cyc   = -1;
    logic [NR-1:0]   start_grant, ack_val, err_val;
    logic [DW-1:0]   start_data;
    logic [2:0]      start_mask;
    logic [NR-1:0]   start_log [$];

    initial begin
        sif.m_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            sif.m_busy = (cyc >= b_rise) && (cyc < b_fall);
        end
    end

    initial forever begin
        @(negedge clk);
        if (cyc >= 1) begin
            eg = mdl_active ? (NR'(1) << mdl_owner) : '0;
            ea = (mdl_active && cyc == mdl_e &&  mdl_ok) ? eg : '0;
            ee = (mdl_active && cyc == mdl_e && !mdl_ok) ? eg : '0;
            check("outputs{grant,ack,err,start,busy}",
                  {50'd0, grant_o, ack_o, err_o, sif.m_start, busy_o},
                  {50'd0, eg, ea, ee, (mdl_active && cyc == mdl_s), mdl_active});
            if (mdl_active) begin
                check("m_data", 64'(sif.m_data), 64'(mdl_data));
                check("m_mask", 64'(sif.m_mask), 64'(mdl_mask));
            end

            if (sif.m_start === 1'b1) begin
                start_cyc   = cyc;
                start_grant = grant_o;
                start_data  = sif.m_data;
                start_mask  = sif.m_mask;
                start_log.push_back(grant_o);
            end
            if (ack_o != '0) begin ack_cyc = cyc; ack_val = ack_o; end
            if (err_o != '0) begin err_cyc = cyc; err_val = err_o; end

            if (reset_i) begin
                mdl_active = 1'b0;
                mdl_ptr    = 0;
                b_rise     = 0;
                b_fall     = 0;
            end else if (mdl_active) begin
                if (cyc == mdl_e) begin
                    mdl_active = 1'b0;
                    mdl_ptr    = (mdl_owner + 1) % NR;
                end
            end else if (req_i != '0 && !sif.m_busy) begin
                mdl_found = 1'b0;
                for (int k = 0; k < NR; k++) begin
                    mdl_idx = (mdl_ptr + k) % NR;
                    if (!mdl_found && req_i[mdl_idx]) begin
                        mdl_found = 1'b1;
                        mdl_owner = mdl_idx;
                    end
                end
                mdl_active = 1'b1;
                mdl_s      = cyc + 1;
                mdl_w      = cyc + 2;
                mdl_data   = req_data_i[mdl_owner];
                mdl_mask   = req_mask_i[mdl_owner];
                if (plan_d < 0 || plan_d >= ST_TO) begin
                    b_rise = 0;
                    b_fall = 0;
                    mdl_e  = mdl_w + ST_TO;
                    mdl_ok = 1'b0;
                end else begin
                    b_rise = mdl_w + plan_d;
                    b_fall = mdl_w + plan_d + plan_l;
                    mdl_r  = mdl_w + plan_d + 1;
                    if (plan_l - 1 >= RUN_TO) begin
                        mdl_e  = mdl_r + RUN_TO;
                        mdl_ok = 1'b0;
                    end else begin
                        mdl_e  = mdl_w + plan_d + plan_l + 1;
                        mdl_ok = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        req_i   = '0;
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        tick();
    endtask

    task automatic randomize_data();
        logic [63:0] r64;
        for (int i = 0; i < NR; i++) begin
            r64           = {$urandom(), $urandom()};
            req_data_i[i] = r64[DW-1:0];
            req_mask_i[i] = 3'($urandom());
        end
    endtask

    logic [NR-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int c0, c1, base, err_before;

    initial begin
        reset_i = 1'b1;
        req_i   = '0;
        randomize_data();
        tick(); tick(); tick();
        reset_i = 1'b0;
        tick();

        check("reset grant", 64'(grant_o), 64'd0);
        check("reset ack/err", 64'({ack_o, err_o}), 64'd0);
        check("reset start/busy", 64'({sif.m_start, busy_o}), 64'd0);
        check("reset m_data", 64'(sif.m_data), 64'd0);
        check("reset m_mask", 64'(sif.m_mask), 64'b111);

        // Single transaction, busy at relative cycles 2..30.
        c0 = cyc;
        plan_d = 0; plan_l = 29;
        req_data_i[0] = 53'h1_0000_0000_0001;
        req_mask_i[0] = 3'b110;
        req_i = 4'b0001;
        tick();
        req_i = '0;
        run_to(c0 + 40);
        check("t1 start latency", 64'(start_cyc - c0), 64'd1);
        check("t1 start grant", 64'(start_grant), 64'b0001);
        check("t1 m_data", 64'(start_data), 64'h1_0000_0000_0001);
        check("t1 m_mask", 64'(start_mask), 64'b110);
        check("t1 ack cycle", 64'(ack_cyc - c0), 64'd32);
        check("t1 ack value", 64'(ack_val), 64'b0001);
        check("t1 model ack cycle", 64'(mdl_e - c0), 64'd32);

        // All four requesters held high: strict rotation.
        do_reset();
        plan_d = 0; plan_l = 3;
        base = start_log.size();
        req_i = 4'b1111;
        run_to(cyc + 36);
        req_i = '0;
        run_to(cyc + 12);
        for (int k = 0; k < 5; k++)
            check("t2 rr order", (base + k < start_log.size()) ? 64'(start_log[base + k]) : 64'hx,
                  64'(rr_exp[k]));

        // Master never answers: start timeout on requester 2.
        do_reset();
        c0 = cyc;
        plan_d = -1;
        req_i = 4'b0100;
        tick();
        req_i = '0;
        run_to(c0 + 11);
        check("t3 err cycle", 64'(err_cyc - c0), 64'd10);
        check("t3 err value", 64'(err_val), 64'b0100);
        check("t3 model err cycle", 64'(mdl_e - c0), 64'd10);
        check("t3 idle after err", 64'({busy_o, grant_o}), 64'd0);

        // Master stuck busy for 5000 cycles: run timeout, then blocked arbitration.
        do_reset();
        c0 = cyc;
        plan_d = 0; plan_l = 5000;
        req_i = 4'b0001;
        tick();
        req_i = '0;
        plan_l = 2;
        run_to(c0 + 4500);
        req_i = 4'b1110;
        run_to(c0 + 4600);
        check("t4 err cycle", 64'(err_cyc - c0), 64'd4099);
        check("t4 err value", 64'(err_val), 64'b0001);
        check("t4 blocked while busy", 64'({busy_o, grant_o}), 64'd0);
        run_to(c0 + 5003);
        req_i = '0;
        run_to(c0 + 5020);
        check("t4 start after busy falls", 64'(start_cyc - c0), 64'd5003);
        check("t4 grant after busy falls", 64'(start_grant), 64'b0010);

        // Requester 1 drops its request during RUN; pointer then sits at 2.
        do_reset();
        c0 = cyc;
        plan_d = 0; plan_l = 10;
        req_i = 4'b0010;
        run_to(c0 + 5);
        req_i = '0;
        run_to(c0 + 20);
        check("t5 ack cycle", 64'(ack_cyc - c0), 64'd13);
        check("t5 ack value", 64'(ack_val), 64'b0010);
        c1 = cyc;
        plan_l = 3;
        req_i = 4'b1101;
        tick();
        req_i = '0;
        run_to(c1 + 10);
        check("t5 next grant", 64'(start_grant), 64'b0100);
        check("t5 next start cycle", 64'(start_cyc - c1), 64'd1);

        // One-cycle reset during RUN, then a fresh request from requester 3.
        do_reset();
        c0 = cyc;
        plan_d = 0; plan_l = 30;
        req_i = 4'b0001;
        tick();
        req_i = '0;
        run_to(c0 + 8);
        err_before = err_cyc;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("t6 reset grant/ack/err", 64'({grant_o, ack_o, err_o}), 64'd0);
        check("t6 reset start/busy", 64'({sif.m_start, busy_o}), 64'd0);
        check("t6 reset m_data", 64'(sif.m_data), 64'd0);
        check("t6 reset m_mask", 64'(sif.m_mask), 64'b111);
        plan_l = 4;
        run_to(c0 + 12);
        c1 = cyc;
        req_i = 4'b1000;
        tick();
        req_i = '0;
        run_to(c1 + 12);
        check("t6 new grant", 64'(start_grant), 64'b1000);
        check("t6 new ack cycle", 64'(ack_cyc - c1), 64'd7);
        check("t6 new ack value", 64'(ack_val), 64'b1000);
        check("t6 no err from aborted txn", 64'(err_cyc), 64'(err_before));

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) req_i = NR'($urandom());
            if ($urandom_range(0, 1) == 0) randomize_data();
            plan_d = int'($urandom_range(0, 9));
            if (plan_d >= ST_TO) plan_d = -1;
            plan_l = int'($urandom_range(1, 24));
            tick();
        end
        req_i = '0;
        run_to(cyc + 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
